// File: rtl/dmr_pkg.sv
// Shared definitions for the data memory responder:
// FSM state encoding, latency limit, address-check helper.
package dmr_pkg;

  // Responder FSM states. At most one request is in flight.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Largest supported wait latency. It sizes the 4-bit wait counter.
  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;

  // A request is in error when it is not word aligned,
  // or when it lies beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr >= 32'(4 * depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU <-> data memory request/response bus.
// The master is the CPU and the slave is the responder.
// Member names carry the direction as seen from the responder.
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmr_word_ram.sv
// Word storage for the responder.
// Writes are synchronous, reads are combinational, and reset
// synchronously clears every word.
module dmr_word_ram #(
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Clear all words on reset; otherwise write one word when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding CPU data memory responder with a fixed access latency.
// Flow:
//   - A request is accepted in IDLE.
//   - The FSM waits LATENCY cycles, then performs the access and enters RESP.
//   - The registered response is presented one cycle later and held until
//     the CPU takes it.
// With this timing, rsp_valid_o rises LATENCY+1 edges after the accept edge.
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  data_mem_responder_if.slave bus
);

  localparam int AW                   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic               accept;
  logic               acc_go;
  logic               acc_wr;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic               acc_err;
  logic               ram_we;
  logic [31:0]        ram_rdata;
  logic [31:0]        rsp_rdata_d;

  assign accept = bus.req_valid_i && (state_q == IDLE);

  // The access happens on the edge that leaves WAIT. With zero latency it
  // happens on the accept edge, so the live request inputs are used in IDLE.
  always_comb begin
    acc_go    = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_go    = accept && (LATENCY == 0);
      acc_wr    = bus.req_write_i;
      acc_addr  = bus.req_addr_i;
      acc_wdata = bus.req_wdata_i;
    end else if (state_q == WAIT) begin
      acc_go = (cnt_q <= CNT_W'(1));
    end
  end

  assign acc_err     = addr_err(acc_addr, DEPTH);
  assign ram_we      = acc_go && acc_wr && !acc_err && !rst_i;
  assign rsp_rdata_d = (acc_wr || acc_err) ? 32'h0 : ram_rdata;

  dmr_word_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (ram_we),
    .addr_i (acc_addr[AW+1:2]),
    .wdata_i(acc_wdata),
    .rdata_o(ram_rdata)
  );

  // Capture the accepted request. This register is datapath only;
  // state_q qualifies whether its contents are meaningful.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q    <= bus.req_write_i;
      addr_q  <= bus.req_addr_i;
      wdata_q <= bus.req_wdata_i;
    end
  end

  // Control FSM: counts the wait, registers the result, and holds the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= LAT_LD;
            if (LATENCY == 0) begin
              state_q     <= RESP;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (acc_go) begin
            cnt_q       <= '0;
            state_q     <= RESP;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          // The first RESP cycle publishes the result registered on entry.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Index 0 drives a LATENCY=2 instance and index 1 drives a LATENCY=0
// instance; both use DEPTH=128.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  rv, rw, rr;
  logic [31:0] ra [2];
  logic [31:0] rd [2];

  int total = 0;
  int bad   = 0;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  assign bus2.req_valid_i = rv[0];
  assign bus2.req_write_i = rw[0];
  assign bus2.req_addr_i  = ra[0];
  assign bus2.req_wdata_i = rd[0];
  assign bus2.rsp_ready_i = rr[0];
  assign bus0.req_valid_i = rv[1];
  assign bus0.req_write_i = rw[1];
  assign bus0.req_addr_i  = ra[1];
  assign bus0.req_wdata_i = rd[1];
  assign bus0.rsp_ready_i = rr[1];

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2.slave));
  data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave));

  function automatic logic g_vld(input int k);
    return (k == 0) ? bus2.rsp_valid_o : bus0.rsp_valid_o;
  endfunction
  function automatic logic g_rdy(input int k);
    return (k == 0) ? bus2.req_ready_o : bus0.req_ready_o;
  endfunction
  function automatic logic [31:0] g_data(input int k);
    return (k == 0) ? bus2.rsp_rdata_o : bus0.rsp_rdata_o;
  endfunction
  function automatic logic g_err(input int k);
    return (k == 0) ? bus2.rsp_err_o : bus0.rsp_err_o;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and let the response handshake complete.
  // lat counts rising edges from the accept edge until rsp_valid_o is seen.
  task automatic issue(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rdata, output logic err);
    int guard;
    guard = 0;
    while (!g_rdy(k) && guard < 20) begin
      step();
      guard++;
    end
    rv[k] = 1'b1; rw[k] = wr; ra[k] = addr; rd[k] = wdata; rr[k] = 1'b1;
    step();
    rv[k] = 1'b0;
    lat = 0;
    while (!g_vld(k) && lat < 40) begin
      step();
      lat++;
    end
    rdata = g_data(k);
    err   = g_err(k);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (g_vld(k) !== 1'b0) begin bad++; $display("FAIL reset_vld[%0d] got=%b want=0", k, g_vld(k)); end
      total++; if (g_data(k) !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h want=0", k, g_data(k)); end
      total++; if (g_err(k) !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b want=0", k, g_err(k)); end
      total++; if (g_rdy(k) !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%b want=1", k, g_rdy(k)); end
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] d; logic e;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, d, e);
    total++; if (lat !== 3) begin bad++; $display("FAIL st_lat got=%0d want=3", lat); end
    total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL st_rsp got=%h/%b want=0/0", d, e); end
    issue(0, 1'b0, 32'h10, 32'h0, lat, d, e);
    total++; if (lat !== 3) begin bad++; $display("FAIL ld_lat got=%0d want=3", lat); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_data got=%h want=deadbeef", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ld_err got=%b want=0", e); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] d; logic e;
    issue(0, 1'b1, 32'h0, 32'h12345678, lat, d, e);
    issue(0, 1'b0, 32'h13, 32'h0, lat, d, e);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL misalign got=%h/%b want=0/1", d, e); end
    issue(0, 1'b1, 32'h200, 32'hBAD0BAD0, lat, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL range_st_err got=%b want=1", e); end
    issue(0, 1'b0, 32'h0, 32'h0, lat, d, e);
    total++; if (d !== 32'h12345678 || e !== 1'b0) begin bad++; $display("FAIL word0_kept got=%h/%b want=12345678/0", d, e); end
    issue(0, 1'b1, 32'h1FC, 32'hCAFE0001, lat, d, e);
    issue(0, 1'b0, 32'h1FC, 32'h0, lat, d, e);
    total++; if (d !== 32'hCAFE0001 || e !== 1'b0) begin bad++; $display("FAIL last_word got=%h/%b want=cafe0001/0", d, e); end
  endtask

  task automatic test_backpressure();
    int guard;
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10; rd[0] = 32'h0; rr[0] = 1'b0;
    step();
    rv[0] = 1'b0;
    guard = 0;
    while (!g_vld(0) && guard < 20) begin step(); guard++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (g_vld(0) !== 1'b1 || g_data(0) !== 32'hDEADBEEF || g_rdy(0) !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d] got vld=%b data=%h rdy=%b want 1/deadbeef/0", i, g_vld(0), g_data(0), g_rdy(0));
      end
      step();
    end
    rr[0] = 1'b1;
    step();
    total++; if (g_rdy(0) !== 1'b1 || g_vld(0) !== 1'b0) begin bad++; $display("FAIL release got rdy=%b vld=%b want 1/0", g_rdy(0), g_vld(0)); end
  endtask

  task automatic test_back_to_back();
    int first, second, guard;
    first = -1; second = -1;
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10; rr[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (g_rdy(0)) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      step();
    end
    rv[0] = 1'b0;
    total++; if (second - first !== 5) begin bad++; $display("FAIL b2b_spacing got=%0d want=5", second - first); end
    guard = 0;
    while (!(g_rdy(0) && !g_vld(0)) && guard < 20) begin step(); guard++; end
  endtask

  task automatic test_reset_wait();
    int lat; logic [31:0] d; logic e;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h8; rd[0] = 32'h55; rr[0] = 1'b1;
    step();
    rv[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (g_vld(0) !== 1'b0 || g_rdy(0) !== 1'b1) begin bad++; $display("FAIL rst_wait got vld=%b rdy=%b want 0/1", g_vld(0), g_rdy(0)); end
    issue(0, 1'b0, 32'h8, 32'h0, lat, d, e);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL rst_dropped got=%h/%b want=0/0", d, e); end
  endtask

  task automatic test_input_change();
    int lat; logic [31:0] d; logic e;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rd[0] = 32'hA5A5A5A5; rr[0] = 1'b1;
    step();
    ra[0] = 32'h24; rd[0] = 32'h11111111; rw[0] = 1'b0;
    lat = 0;
    while (!g_vld(0) && lat < 40) begin step(); lat++; end
    rv[0] = 1'b0;
    total++; if (lat !== 3 || g_err(0) !== 1'b0 || g_data(0) !== 32'h0) begin
      bad++; $display("FAIL chg_rsp got lat=%0d err=%b data=%h want 3/0/0", lat, g_err(0), g_data(0)); end
    step();
    issue(0, 1'b0, 32'h20, 32'h0, lat, d, e);
    total++; if (d !== 32'hA5A5A5A5) begin bad++; $display("FAIL chg_kept got=%h want=a5a5a5a5", d); end
    issue(0, 1'b0, 32'h24, 32'h0, lat, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL chg_ignored got=%h want=0", d); end
  endtask

  task automatic test_lat0();
    int lat; logic [31:0] d; logic e;
    issue(1, 1'b1, 32'h4, 32'h1, lat, d, e);
    total++; if (lat !== 1) begin bad++; $display("FAIL l0_st_lat got=%0d want=1", lat); end
    issue(1, 1'b0, 32'h4, 32'h0, lat, d, e);
    total++; if (lat !== 1) begin bad++; $display("FAIL l0_ld_lat got=%0d want=1", lat); end
    total++; if (d !== 32'h1 || e !== 1'b0) begin bad++; $display("FAIL l0_ld_data got=%h/%b want=1/0", d, e); end
  endtask

  initial begin
    rst = 1'b1; rv = '0; rw = '0; rr = '0;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    #1;
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_wait();
    test_input_change();
    test_lat0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
